// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: host-side data and board-pin bundle for the 7-segment scanner
// master: drives en, hex_mode, load, din, dp_in, blank_in; observes SEG_COM, SEG_DATA, frame_done
// slave: the scanner itself
interface seg7_scan_ctrl_if #(parameter int N_DIGITS = 6);
  logic                    en;
  logic                    hex_mode;
  logic                    load;
  logic [4*N_DIGITS-1:0]   din;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     blank_in;
  logic [N_DIGITS-1:0]     SEG_COM;
  logic [7:0]              SEG_DATA;
  logic                    frame_done;
  modport master (output en, hex_mode, load, din, dp_in, blank_in, input SEG_COM, SEG_DATA, frame_done);
  modport slave (input en, hex_mode, load, din, dp_in, blank_in, output SEG_COM, SEG_DATA, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered multiplexed 7-segment scan controller
// ports: clk, nRESET (async active-low), bus (slave): en, hex_mode, load, din, dp_in, blank_in in;
//        SEG_COM (active-low strobes, digit k on bit N_DIGITS-1-k), SEG_DATA {a..g,dp}, frame_done out
// option: define SEG7_LZB_EN for leading-zero blanking
module seg7_scan_ctrl #(
  parameter int N_DIGITS = 6,
  parameter int SCAN_DIV = 25000
) (
  input logic             clk,
  input logic             nRESET,
  seg7_scan_ctrl_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(N_DIGITS - 1);
  logic [PW-1:0] pre;
  logic [SW-1:0] slot;
  logic [4*N_DIGITS-1:0] sh_din, ds_din, s_din;
  logic [N_DIGITS-1:0] sh_dp, sh_blank, ds_dp, ds_blank, s_dp, s_blank, one_hot;
  logic [3:0] nib;
  logic [6:0] raw, segs;
  logic [7:0] data;
  logic tick, first, lz;
  assign tick = bus.en && pre == PRE_LAST;
  assign first = slot == '0;
  // slot 0 shows the frame being copied in this edge, so it reads the shadow directly
  assign s_din = first ? sh_din : ds_din;
  assign s_dp = first ? sh_dp : ds_dp;
  assign s_blank = first ? sh_blank : ds_blank;
  assign nib = 4'(s_din >> {slot, 2'b00});
  assign one_hot = {{(N_DIGITS-1){1'b0}}, 1'b1} << (N_DIGITS - 1 - int'(slot));
  always_comb begin
    case (nib)
      4'h0: raw = 7'b1111110;
      4'h1: raw = 7'b0110000;
      4'h2: raw = 7'b1101101;
      4'h3: raw = 7'b1111001;
      4'h4: raw = 7'b0110011;
      4'h5: raw = 7'b1011011;
      4'h6: raw = 7'b1011111;
      4'h7: raw = 7'b1110000;
      4'h8: raw = 7'b1111111;
      4'h9: raw = 7'b1111011;
      4'ha: raw = 7'b1110111;
      4'hb: raw = 7'b0011111;
      4'hc: raw = 7'b1001110;
      4'hd: raw = 7'b0111101;
      4'he: raw = 7'b1001111;
      default: raw = 7'b1000111;
    endcase
  end
  assign segs = (nib > 4'h9 && !bus.hex_mode) ? 7'b0 : raw;
`ifdef SEG7_LZB_EN
  // a digit is suppressed when it and every higher digit are zero; digit 0 always shows
  always_comb begin
    lz = slot != '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (i >= int'(slot) && s_din[4*i +: 4] != 4'h0) lz = 1'b0;
  end
`else
  assign lz = 1'b0;
`endif
  assign data = s_blank[slot] ? 8'h00 : {lz ? 7'b0 : segs, s_dp[slot]};
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      pre <= '0;
      slot <= '0;
      sh_din <= '0;
      sh_dp <= '0;
      sh_blank <= '0;
      ds_din <= '0;
      ds_dp <= '0;
      ds_blank <= '0;
      bus.SEG_COM <= '1;
      bus.SEG_DATA <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_din <= bus.din;
        sh_dp <= bus.dp_in;
        sh_blank <= bus.blank_in;
      end
      if (!bus.en) begin
        pre <= '0;
        slot <= '0;
        bus.SEG_COM <= '1;
        bus.SEG_DATA <= '0;
        bus.frame_done <= 1'b0;
      end else if (tick) begin
        pre <= '0;
        slot <= slot == SLOT_LAST ? '0 : slot + SW'(1);
        bus.SEG_COM <= ~one_hot;
        bus.SEG_DATA <= data;
        bus.frame_done <= slot == SLOT_LAST;
        if (first) begin
          ds_din <= sh_din;
          ds_dp <= sh_dp;
          ds_blank <= sh_blank;
        end
      end else begin
        pre <= pre + PW'(1);
        bus.frame_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl (N_DIGITS=6, SCAN_DIV=4)
module tb_seg7_scan_ctrl;
  localparam int N = 6;
  localparam int D = 4;
  logic clk = 1'b0;
  logic nRESET = 1'b0;
  int tests = 0;
  int fails = 0;
  seg7_scan_ctrl_if #(.N_DIGITS(N)) bus();
  seg7_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(D)) dut (.clk(clk), .nRESET(nRESET), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [7:0] exp_d(input logic [3:0] n, input logic dp, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'ha: s = 7'b1110111;
      4'hb: s = 7'b0011111;
      4'hc: s = 7'b1001110;
      4'hd: s = 7'b0111101;
      4'he: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (n > 4'h9 && !hex) s = 7'b0;
    return {s, dp};
  endfunction
  function automatic logic [N-1:0] exp_com(input int k);
    logic [N-1:0] b;
    b = 6'b100000;
    return ~(b >> k);
  endfunction
  task automatic restart(input logic [4*N-1:0] d, input logic [N-1:0] dp, input logic [N-1:0] bl, input logic hex);
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.din = d;
    bus.dp_in = dp;
    bus.blank_in = bl;
    bus.hex_mode = hex;
    step();
    bus.load = 1'b0;
    bus.en = 1'b1;
    step(D);
  endtask
  task automatic test_reset();
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.hex_mode = 1'b1;
    bus.din = '0;
    bus.dp_in = '0;
    bus.blank_in = '0;
    step(2);
    tests++;
    if (bus.SEG_COM !== 6'b111111 || bus.SEG_DATA !== 8'h00 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset com=%b data=%b fd=%b want 111111 00000000 0", bus.SEG_COM, bus.SEG_DATA, bus.frame_done);
    end
    nRESET = 1'b1;
    step(3);
    tests++;
    if (bus.SEG_COM !== 6'b111111 || bus.SEG_DATA !== 8'h00) begin
      fails++;
      $display("FAIL pre_first_tick com=%b data=%b want 111111 00000000", bus.SEG_COM, bus.SEG_DATA);
    end
    step();
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b11111100) begin
      fails++;
      $display("FAIL first_slot com=%b data=%b want 011111 11111100", bus.SEG_COM, bus.SEG_DATA);
    end
  endtask
  task automatic test_scan();
    logic [4*N-1:0] d;
    d = 24'h654321;
    restart(d, '0, '0, 1'b1);
    for (int k = 0; k < N; k++) begin
      if (k > 0) step(D);
      tests++;
      if (bus.SEG_COM !== exp_com(k) || bus.SEG_DATA !== exp_d(d[4*k +: 4], 1'b0, 1'b1) || bus.frame_done !== (k == N-1)) begin
        fails++;
        $display("FAIL scan k=%0d com=%b data=%b fd=%b want %b %b %b", k, bus.SEG_COM, bus.SEG_DATA, bus.frame_done,
                 exp_com(k), exp_d(d[4*k +: 4], 1'b0, 1'b1), k == N-1);
      end
    end
    step();
    tests++;
    if (bus.frame_done !== 1'b0 || bus.SEG_COM !== 6'b111110) begin
      fails++;
      $display("FAIL frame_done_width fd=%b com=%b want 0 111110", bus.frame_done, bus.SEG_COM);
    end
  endtask
  task automatic test_hex();
    restart(24'h00000a, '0, '0, 1'b1);
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b11101110) begin
      fails++;
      $display("FAIL hex_on com=%b data=%b want 011111 11101110", bus.SEG_COM, bus.SEG_DATA);
    end
    restart(24'h00000a, '0, '0, 1'b0);
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b00000000) begin
      fails++;
      $display("FAIL hex_off com=%b data=%b want 011111 00000000", bus.SEG_COM, bus.SEG_DATA);
    end
  endtask
  task automatic test_tear_free();
    logic [4*N-1:0] d;
    d = 24'h654321;
    restart(d, '0, '0, 1'b1);
    step(3 * D);
    bus.load = 1'b1;
    bus.din = 24'h999999;
    step();
    bus.load = 1'b0;
    step(D - 1);
    for (int k = 4; k < N; k++) begin
      if (k > 4) step(D);
      tests++;
      if (bus.SEG_COM !== exp_com(k) || bus.SEG_DATA !== exp_d(d[4*k +: 4], 1'b0, 1'b1)) begin
        fails++;
        $display("FAIL tear_old k=%0d com=%b data=%b want %b %b", k, bus.SEG_COM, bus.SEG_DATA, exp_com(k), exp_d(d[4*k +: 4], 1'b0, 1'b1));
      end
    end
    for (int k = 0; k < N; k++) begin
      step(D);
      tests++;
      if (bus.SEG_COM !== exp_com(k) || bus.SEG_DATA !== 8'b11110110) begin
        fails++;
        $display("FAIL tear_new k=%0d com=%b data=%b want %b 11110110", k, bus.SEG_COM, bus.SEG_DATA, exp_com(k));
      end
    end
    step(D - 1);
    bus.load = 1'b1;
    bus.din = 24'h111111;
    step();
    bus.load = 1'b0;
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b11110110) begin
      fails++;
      $display("FAIL copy_edge_deferred com=%b data=%b want 011111 11110110", bus.SEG_COM, bus.SEG_DATA);
    end
    step(N * D);
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b01100000) begin
      fails++;
      $display("FAIL copy_edge_next com=%b data=%b want 011111 01100000", bus.SEG_COM, bus.SEG_DATA);
    end
  endtask
  task automatic test_blank_dp_en();
    restart(24'h654321, 6'b000001, 6'b000010, 1'b1);
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b01100001) begin
      fails++;
      $display("FAIL dp_digit0 com=%b data=%b want 011111 01100001", bus.SEG_COM, bus.SEG_DATA);
    end
    step(D);
    tests++;
    if (bus.SEG_COM !== 6'b101111 || bus.SEG_DATA !== 8'b00000000) begin
      fails++;
      $display("FAIL blank_digit1 com=%b data=%b want 101111 00000000", bus.SEG_COM, bus.SEG_DATA);
    end
    step();
    bus.en = 1'b0;
    step();
    tests++;
    if (bus.SEG_COM !== 6'b111111 || bus.SEG_DATA !== 8'h00 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL en_off com=%b data=%b fd=%b want 111111 00000000 0", bus.SEG_COM, bus.SEG_DATA, bus.frame_done);
    end
    bus.en = 1'b1;
    step(D - 1);
    tests++;
    if (bus.SEG_COM !== 6'b111111) begin
      fails++;
      $display("FAIL reenable_dark com=%b want 111111", bus.SEG_COM);
    end
    step();
    tests++;
    if (bus.SEG_COM !== 6'b011111 || bus.SEG_DATA !== 8'b01100001) begin
      fails++;
      $display("FAIL reenable_digit0 com=%b data=%b want 011111 01100001", bus.SEG_COM, bus.SEG_DATA);
    end
  endtask
  task automatic test_lzb();
    logic [7:0] want [N];
`ifdef SEG7_LZB_EN
    want = '{8'b11111100, 8'b10110110, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000001};
`else
    want = '{8'b11111100, 8'b10110110, 8'b11111100, 8'b11111100, 8'b11111100, 8'b11111101};
`endif
    restart(24'h000050, 6'b100000, '0, 1'b1);
    for (int k = 0; k < N; k++) begin
      if (k > 0) step(D);
      tests++;
      if (bus.SEG_COM !== exp_com(k) || bus.SEG_DATA !== want[k]) begin
        fails++;
        $display("FAIL lzb k=%0d com=%b data=%b want %b %b", k, bus.SEG_COM, bus.SEG_DATA, exp_com(k), want[k]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_tear_free();
    test_blank_dp_en();
    test_lzb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
